// File: rtl/conv_frame_loader_if.sv
// rtl/conv_frame_loader_if.sv - weight/pixel stream bundle feeding conv_frame_loader
//   s_valid  master->slave  beat valid
//   s_ready  slave->master  loader can accept a beat
//   s_data   master->slave  weight or pixel value, PIX_W bits
//   s_last   master->slave  high only on the final pixel of a frame
interface conv_frame_loader_if #(
    parameter int PIX_W = 2
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/conv_frame_loader.sv
// rtl/conv_frame_loader.sv - assembles a serial weight+pixel frame and commits it to the PE array buses
// Optional feature macro: FILTER_REUSE_EN (adds keep_filter; a frame may reuse the committed weights)
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   stream       conv_frame_loader_if.slave: s_valid / s_ready / s_data / s_last
//   keep_filter  (FILTER_REUSE_EN only) sampled with frame_ack: skip weight load for next frame
//   pe_in        committed image, pixel k at [PIX_W*k +: PIX_W]
//   pe_filter    committed weights, weight j at [PIX_W*j +: PIX_W]
//   frame_valid  committed frame held for the consumer
//   frame_ack    consumer has taken the frame (only meaningful in HOLD)
//   err_len      1-cycle pulse when a frame is dropped for a misplaced or missing s_last
module conv_frame_loader #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int K     = 3,
    parameter int PIX_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    conv_frame_loader_if.slave            stream,
`ifdef FILTER_REUSE_EN
    input  logic                          keep_filter,
`endif
    output logic [IMG_W*IMG_H*PIX_W-1:0]  pe_in,
    output logic [K*K*PIX_W-1:0]          pe_filter,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic                          err_len
);
    localparam int N_PIX    = IMG_W * IMG_H;
    localparam int N_WGT    = K * K;
    localparam int IMG_BITS = N_PIX * PIX_W;
    localparam int FLT_BITS = N_WGT * PIX_W;
    localparam int PCW      = $clog2(N_PIX);
    localparam int WCW      = $clog2(N_WGT);
    localparam logic [PCW-1:0] P_LAST = PCW'(N_PIX - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(N_WGT - 1);

    typedef enum logic [1:0] {
        FILT = 2'd0,
        IMG  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PCW-1:0]        p_cnt;
    logic [WCW-1:0]        w_cnt;
    logic [IMG_BITS-1:0]   img_stage;
    logic [IMG_BITS-1:0]   img_next;
    logic [FLT_BITS-1:0]   filt_stage;
    logic                  beat;
    logic                  commit;
    logic                  drop;
    logic                  reuse;

    // Ready is forced low while reset is held so nothing is accepted mid-reset.
    assign stream.s_ready = rst_n && (state != HOLD);
    assign beat           = stream.s_valid && stream.s_ready;

`ifdef FILTER_REUSE_EN
    logic filt_loaded;

    assign reuse = keep_filter && filt_loaded;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_loaded <= 1'b0;
        end else if (commit) begin
            filt_loaded <= 1'b1;
        end
    end
`else
    assign reuse = 1'b0;
`endif

    // Staging image with the current pixel merged in, so the commit edge can
    // publish the final pixel without waiting a cycle.
    always_comb begin
        img_next = img_stage;
        if (beat && (state == IMG)) begin
            img_next[PIX_W*int'(p_cnt) +: PIX_W] = stream.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        drop       = 1'b0;
        case (state)
            FILT: begin
                // s_last is deliberately ignored while loading weights.
                if (beat && (w_cnt == W_LAST)) begin
                    state_next = IMG;
                end
            end
            IMG: begin
                if (beat) begin
                    if (p_cnt == P_LAST) begin
                        if (stream.s_last) begin
                            commit     = 1'b1;
                            state_next = HOLD;
                        end else begin
                            drop       = 1'b1;
                            state_next = FILT;
                        end
                    end else if (stream.s_last) begin
                        drop       = 1'b1;
                        state_next = FILT;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_next = reuse ? IMG : FILT;
                end
            end
            default: begin
                state_next = FILT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_cnt       <= '0;
            w_cnt       <= '0;
            img_stage   <= '0;
            filt_stage  <= '0;
            pe_in       <= '0;
            pe_filter   <= '0;
            frame_valid <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            err_len   <= drop;
            img_stage <= img_next;

            if (beat && (state == FILT)) begin
                filt_stage[PIX_W*int'(w_cnt) +: PIX_W] <= stream.s_data;
                w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + WCW'(1);
            end

            if (beat && (state == IMG)) begin
                if (commit || drop) begin
                    p_cnt <= '0;
                    w_cnt <= '0;
                end else begin
                    p_cnt <= p_cnt + PCW'(1);
                end
            end

            // A reuse frame enters IMG straight from HOLD, so filt_stage still
            // equals the committed weights and recommitting it retains them.
            if (commit) begin
                pe_in       <= img_next;
                pe_filter   <= filt_stage;
                frame_valid <= 1'b1;
            end else if ((state == HOLD) && frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_loader.sv
// tb/tb_conv_frame_loader.sv - table-driven self-checking bench for conv_frame_loader
module tb_conv_frame_loader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_ack;
    logic         frame_valid;
    logic         err_len;
    logic [287:0] pe_in;
    logic [17:0]  pe_filter;
`ifdef FILTER_REUSE_EN
    logic         keep_filter;
`endif

    conv_frame_loader_if #(.PIX_W(2)) stream();

    conv_frame_loader #(
        .IMG_W(12),
        .IMG_H(12),
        .K(3),
        .PIX_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stream(stream),
`ifdef FILTER_REUSE_EN
        .keep_filter(keep_filter),
`endif
        .pe_in(pe_in),
        .pe_filter(pe_filter),
        .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    logic [287:0] exp_img;

    typedef struct {
        logic [17:0] weights;
        int          mode;
        int          last_at;
        bit          flt_last;
        bit          gaps;
        int          hold;
        bit          exp_commit;
        logic [17:0] exp_flt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] pix_val(input int mode, input int k);
        case (mode)
            0:       return 2'd0;
            1:       return (k == 0 || k == 143) ? 2'd1 : 2'd0;
            2:       return 2'((k * 5 + k / 12) % 4);
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [287:0] build_img(input int mode);
        logic [287:0] v;
        v = '0;
        for (int k = 0; k < 144; k++) v[2*k +: 2] = pix_val(mode, k);
        return v;
    endfunction

    // Starts and ends at a negedge; returns just after the accepting edge.
    task automatic do_beat(input logic [1:0] d, input logic l, input bit gap);
        int guard;
        guard = 0;
        if (gap) begin
            stream.s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        stream.s_valid = 1'b1;
        stream.s_data  = d;
        stream.s_last  = l;
        while (!stream.s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 288'd0, 288'd1);
        @(negedge clk);
        stream.s_valid = 1'b0;
        stream.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [17:0] w, input int mode, input int last_at,
                              input bit flt_last, input bit gaps, input bit with_w);
        bit l;
        if (with_w) begin
            for (int j = 0; j < 9; j++)
                do_beat(w[2*j +: 2], flt_last, gaps && ($urandom_range(0, 2) == 0));
        end
        for (int k = 0; k < 144; k++) begin
            l = (k == last_at);
            do_beat(pix_val(mode, k), l, gaps && ($urandom_range(0, 2) == 0));
            if (l && k < 143) return;
        end
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_frame_valid", frame_valid, 0);
        check("ack_s_ready", stream.s_ready, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                weights     mode last flt_l gaps hold commit exp_flt
        vecs[0] = '{18'h00100, 1, 143, 1'b0, 1'b1, 5, 1'b1, 18'h00100};
        vecs[1] = '{18'h3FFFF, 2, 50,  1'b0, 1'b0, 0, 1'b0, 18'h00100};
        vecs[2] = '{18'h2AAAA, 2, -1,  1'b0, 1'b0, 0, 1'b0, 18'h00100};
        vecs[3] = '{18'h1B2C5, 2, 143, 1'b1, 1'b1, 2, 1'b1, 18'h1B2C5};
        vecs[4] = '{18'h3FFFF, 3, 0,   1'b0, 1'b0, 0, 1'b0, 18'h1B2C5};
        vecs[5] = '{18'h00000, 0, 143, 1'b0, 1'b0, 0, 1'b1, 18'h00000};
        vecs[6] = '{18'h24924, 3, 142, 1'b0, 1'b0, 0, 1'b0, 18'h00000};
        vecs[7] = '{18'h24924, 3, 143, 1'b0, 1'b1, 1, 1'b1, 18'h24924};

        rst_n          = 1'b0;
        frame_ack      = 1'b0;
        stream.s_valid = 1'b0;
        stream.s_data  = 2'd0;
        stream.s_last  = 1'b0;
`ifdef FILTER_REUSE_EN
        keep_filter    = 1'b0;
`endif
        exp_img = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pe_in", pe_in, 0);
        check("rst_pe_filter", pe_filter, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_err_len", err_len, 0);
        check("rst_s_ready", stream.s_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", stream.s_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].weights, vecs[i].mode, vecs[i].last_at,
                       vecs[i].flt_last, vecs[i].gaps, 1'b1);
            if (vecs[i].exp_commit) exp_img = build_img(vecs[i].mode);
            check($sformatf("v%0d_err_len", i), err_len, {287'd0, !vecs[i].exp_commit});
            check($sformatf("v%0d_frame_valid", i), frame_valid, {287'd0, vecs[i].exp_commit});
            check($sformatf("v%0d_pe_in", i), pe_in, exp_img);
            check($sformatf("v%0d_pe_filter", i), pe_filter, vecs[i].exp_flt);
            if (i == 0) begin
                check("t2_pix0", pe_in[1:0], 2'd1);
                check("t2_pix2", pe_in[5:4], 2'd0);
                check("t2_pix143", pe_in[287:286], 2'd1);
            end
            if (vecs[i].exp_commit) begin
                check($sformatf("v%0d_hold_ready", i), stream.s_ready, 0);
                // Offered beats during HOLD must not be taken.
                stream.s_valid = 1'b1;
                stream.s_data  = 2'd2;
                stream.s_last  = 1'b1;
                for (int c = 0; c < vecs[i].hold; c++) begin
                    @(negedge clk);
                    check($sformatf("v%0d_hold%0d_ready", i, c), stream.s_ready, 0);
                    check($sformatf("v%0d_hold%0d_fv", i, c), frame_valid, 1);
                    check($sformatf("v%0d_hold%0d_pe_in", i, c), pe_in, exp_img);
                end
                stream.s_valid = 1'b0;
                stream.s_last  = 1'b0;
                do_ack();
            end else begin
                @(negedge clk);
                check($sformatf("v%0d_err_pulse_end", i), err_len, 0);
                check($sformatf("v%0d_fv_low", i), frame_valid, 0);
            end
        end

        // frame_ack tied high: ignored outside HOLD, single HOLD cycle.
        frame_ack = 1'b1;
        send_frame(18'h0C3F1, 2, 143, 1'b0, 1'b0, 1'b1);
        exp_img = build_img(2);
        check("tied_fv", frame_valid, 1);
        check("tied_ready", stream.s_ready, 0);
        check("tied_pe_filter", pe_filter, 18'h0C3F1);
        check("tied_pe_in", pe_in, exp_img);
        @(negedge clk);
        frame_ack = 1'b0;
        check("tied_fv_drop", frame_valid, 0);
        check("tied_ready_back", stream.s_ready, 1);

        // Reset at pixel 70 aborts the frame and clears committed outputs.
        for (int j = 0; j < 9; j++) do_beat(2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 70; k++) do_beat(pix_val(3, k), 1'b0, 1'b0);
        rst_n          = 1'b0;
        stream.s_valid = 1'b1;
        stream.s_data  = 2'd3;
        repeat (2) @(negedge clk);
        check("midrst_pe_in", pe_in, 0);
        check("midrst_pe_filter", pe_filter, 0);
        check("midrst_fv", frame_valid, 0);
        check("midrst_err", err_len, 0);
        check("midrst_ready", stream.s_ready, 0);
        rst_n          = 1'b1;
        stream.s_valid = 1'b0;
        @(negedge clk);
        send_frame(18'h2D1E4, 2, 143, 1'b0, 1'b0, 1'b1);
        exp_img = build_img(2);
        check("after_rst_fv", frame_valid, 1);
        check("after_rst_pe_filter", pe_filter, 18'h2D1E4);
        check("after_rst_pe_in", pe_in, exp_img);

`ifdef FILTER_REUSE_EN
        keep_filter = 1'b1;
        frame_ack   = 1'b1;
        @(negedge clk);
        frame_ack   = 1'b0;
        keep_filter = 1'b0;
        check("reuse_ready", stream.s_ready, 1);
        send_frame(18'h3FFFF, 3, 143, 1'b0, 1'b0, 1'b0);
        exp_img = build_img(3);
        check("reuse_fv", frame_valid, 1);
        check("reuse_pe_filter", pe_filter, 18'h2D1E4);
        check("reuse_pe_in", pe_in, exp_img);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(18'h11111, 1, 143, 1'b0, 1'b0, 1'b1);
        exp_img = build_img(1);
        check("reload_pe_filter", pe_filter, 18'h11111);
        check("reload_pe_in", pe_in, exp_img);
        do_ack();
`else
        do_ack();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
